miner_nonce_scheduler: RTL and testbench
========================================

Name: miner_nonce_scheduler

Overview:
Parametrised job controller for the mining datapath. It accepts one 640-bit block header job, sweeps the nonce field over a programmed inclusive range and issues headers to a downstream hash pipeline through a valid/ready handshake. It compares every returned digest against a 256-bit target and reports the first hit. It tracks in-flight credits and drains outstanding results before declaring the job done.

Parameters:
NONCE_W, 32, nonce width; the nonce replaces block_header[NONCE_W-1:0] on issue
MAX_INFLIGHT, 64, maximum issued-but-unreturned hashes; must be at least 1
CNT_W, $clog2(MAX_INFLIGHT+1), width of the in-flight counter (derived)

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  job start pulse; sampled only in IDLE
block_header  in  640  job header; latched on an accepted start
nonce_start  in  NONCE_W  first nonce, inclusive; latched on start
nonce_end  in  NONCE_W  last nonce, inclusive; latched on start
target  in  256  unsigned threshold; latched on start
busy  out  1  high from the cycle after start until done
done  out  1  single-cycle job-complete pulse
found  out  1  a hit occurred in the current or last job; sticky
found_nonce  out  NONCE_W  nonce of the first hit
hash_valid  out  1  issue request to the hash pipeline
hash_ready  in  1  hash pipeline accepts the issue
hash_header  out  640  {latched_header[639:NONCE_W], cur_nonce}
hash_nonce  out  NONCE_W  tag; equals cur_nonce
res_valid  in  1  result strobe; results may return in any order
res_nonce  in  NONCE_W  tag of the returned result
res_digest  in  256  digest, treated as an unsigned integer

Behaviour:
- Reset values: busy=0, done=0, found=0, found_nonce=0, hash_valid=0, hash_header=0, hash_nonce=0. State=IDLE, inflight=0.
- IDLE:
  - start latches header, range and target, clears found/found_nonce and sets cur_nonce=nonce_start.
  - If nonce_end<nonce_start, go to DONE (empty job). Otherwise go to ISSUE.
  - res_valid in IDLE is ignored.
- ISSUE:
  - hash_valid = (inflight<MAX_INFLIGHT); the outputs stay stable while valid&&!ready.
  - A transfer happens on hash_valid&&hash_ready.
  - On a transfer with cur_nonce==nonce_end, go to DRAIN. No increment is done, so nonce_end=all-ones never wraps. Otherwise cur_nonce increments by 1.
- Hit: res_valid && res_digest<target (strict) && !found.
  - found=1 and found_nonce=res_nonce, registered the cycle after res_valid.
  - The FSM goes to DRAIN. hash_valid drops the cycle after the hit; a transfer in the hit cycle itself still counts.
  - Later hits in the same job are ignored.
- inflight: +1 on transfer, -1 on res_valid, unchanged when both occur in the same cycle. res_valid with inflight==0 is ignored and the counter never underflows.
- DRAIN: hash_valid=0. When inflight==0, go to DONE; if inflight is already 0 on entry, go to DONE the next cycle.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. found and found_nonce hold until the next start.
- start outside IDLE is ignored.
- Latency: the first hash_valid is asserted the cycle after start. Throughput is one issue per cycle while credits remain.
- Reset mid-job: returns to IDLE immediately with all reset values. Results still in the pipeline that arrive later are ignored.

Optional Feature:
MINER_HASH_COUNT_EN:
- Defined: adds output hash_count [31:0].
  - Counts res_valid results accepted in DRAIN or ISSUE.
  - Cleared on accepted start and on reset; saturates at 32'hFFFF_FFFF.
  - Holds its value after done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
Bench model: 5-cycle in-order pipeline, hash_ready=1, digest={nonce,224'h0}. target={32'h10,224'h0}, so a hit means nonce<16.
1. Range 20..30 -> 11 transfers with nonces 20..30; no hit; done pulse after the last result; found=0; hash_count=11.
2. Range 10..40 -> found=1, found_nonce=10; issue stops; all in-flight results drain; done=1 once; later digests below target are ignored.
3. MAX_INFLIGHT=4 with a pipeline latency of 10 -> hash_valid is never high while inflight==4; inflight peaks at 4; all 8 nonces of range 100..107 are issued.
4. nonce_start=FFFF_FFFE, nonce_end=FFFF_FFFF -> exactly 2 issues and no wrap to 0; done follows. Then nonce_start=5, nonce_end=4 -> done on the second cycle after start with zero issues.
5. Random hash_ready deassertion -> hash_header and hash_nonce are stable while stalled; no nonce is skipped or duplicated over range 0..63.
6. reset asserted mid-ISSUE, then start with range 0..3 -> stale results are ignored; the new job completes with correct found, found_nonce (0) and inflight returning to 0.

Source files
------------

// File: rtl/miner_nonce_scheduler.sv
// rtl/miner_nonce_scheduler.sv - nonce sweep job controller with credit-limited issue and first-hit capture
// Optional MINER_HASH_COUNT_EN adds a saturating hash_count of results accepted during a job.
module miner_nonce_scheduler #(
  parameter int NONCE_W      = 32,
  parameter int MAX_INFLIGHT = 64,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [639:0]       block_header,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic [255:0]       target,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               hash_valid,
  input  logic               hash_ready,
  output logic [639:0]       hash_header,
  output logic [NONCE_W-1:0] hash_nonce,
  input  logic               res_valid,
  input  logic [NONCE_W-1:0] res_nonce,
`ifdef MINER_HASH_COUNT_EN
  input  logic [255:0]       res_digest,
  output logic [31:0]        hash_count
`else
  input  logic [255:0]       res_digest
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  state_t                 state;
  logic [639-NONCE_W:0]   hdr_hi;
  logic [NONCE_W-1:0]     end_q;
  logic [NONCE_W-1:0]     cur_nonce;
  logic [255:0]           target_q;
  logic [CNT_W-1:0]       inflight;
  logic                   xfer;
  logic                   active;
  logic                   res_take;
  logic                   hit;
  logic                   unused_hdr_bits;

  // The low header bits are always replaced by the nonce, so they are never stored.
  assign unused_hdr_bits = ^block_header[NONCE_W-1:0];

  assign hash_valid  = (state == S_ISSUE) && (inflight < MAX_CNT);
  assign hash_header = {hdr_hi, cur_nonce};
  assign hash_nonce  = cur_nonce;

  assign xfer     = hash_valid && hash_ready;
  assign active   = (state == S_ISSUE) || (state == S_DRAIN);
  assign res_take = res_valid && active && (inflight != '0);
  assign hit      = res_valid && active && (res_digest < target_q) && !found;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      hdr_hi      <= '0;
      end_q       <= '0;
      cur_nonce   <= '0;
      target_q    <= '0;
      inflight    <= '0;
`ifdef MINER_HASH_COUNT_EN
      hash_count  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            hdr_hi      <= block_header[639:NONCE_W];
            end_q       <= nonce_end;
            target_q    <= target;
            cur_nonce   <= nonce_start;
            found       <= 1'b0;
            found_nonce <= '0;
            busy        <= 1'b1;
            state       <= (nonce_end < nonce_start) ? S_FIN : S_ISSUE;
`ifdef MINER_HASH_COUNT_EN
            hash_count  <= '0;
`endif
          end
        end
        S_ISSUE: begin
          // Hold cur_nonce on the final transfer so an all-ones end never wraps.
          if (xfer) begin
            if (cur_nonce == end_q) state <= S_DRAIN;
            else                    cur_nonce <= cur_nonce + NONCE_W'(1);
          end
          if (hit) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (inflight == '0) state <= S_FIN;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (hit) begin
        found       <= 1'b1;
        found_nonce <= res_nonce;
      end

      if (xfer && !res_take)      inflight <= inflight + CNT_W'(1);
      else if (!xfer && res_take) inflight <= inflight - CNT_W'(1);

`ifdef MINER_HASH_COUNT_EN
      if (res_take && (hash_count != 32'hFFFF_FFFF)) hash_count <= hash_count + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// tb/tb_miner_nonce_scheduler.sv - directed self-checking bench for miner_nonce_scheduler
module tb_miner_nonce_scheduler;
  localparam int NW = 32;
  localparam int MI = 4;
  localparam logic [255:0] T16 = {32'h10, 224'h0};
  localparam logic [255:0] T0  = 256'h0;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [639:0]   block_header;
  logic [NW-1:0]  nonce_start;
  logic [NW-1:0]  nonce_end;
  logic [255:0]   target;
  logic           busy;
  logic           done;
  logic           found;
  logic [NW-1:0]  found_nonce;
  logic           hash_valid;
  logic           hash_ready = 1'b1;
  logic [639:0]   hash_header;
  logic [NW-1:0]  hash_nonce;
  logic           res_valid = 1'b0;
  logic [NW-1:0]  res_nonce = '0;
  logic [255:0]   res_digest = '0;
`ifdef MINER_HASH_COUNT_EN
  logic [31:0]    hash_count;
`endif

  miner_nonce_scheduler #(.NONCE_W(NW), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .reset(reset), .start(start), .block_header(block_header),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_header(hash_header),
    .hash_nonce(hash_nonce), .res_valid(res_valid), .res_nonce(res_nonce),
`ifdef MINER_HASH_COUNT_EN
    .res_digest(res_digest), .hash_count(hash_count)
`else
    .res_digest(res_digest)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream model: fixed-latency in-order pipeline, digest = {nonce, 224'h0}
  int            lat = 5;
  bit            rand_ready = 1'b0;
  int            mif = 0;
  int            peak = 0;
  int            n_issue = 0;
  int            ndone = 0;
  bit            seen_zero = 1'b0;
  logic [NW-1:0] exp_nonce = '0;
  bit            pv [16];
  bit [NW-1:0]   pn [16];
  bit            prev_xfer = 1'b0, prev_racc = 1'b0, prev_reset = 1'b1;
  bit            prev_valid = 1'b0, prev_ready = 1'b1;
  logic [NW-1:0] prev_nonce = '0;
  logic [639:0]  prev_hdr = '0;

  always @(negedge clk) begin
    bit xfer;
    if (prev_reset)                    mif = 0;
    else if (prev_xfer && !prev_racc)  mif++;
    else if (!prev_xfer && prev_racc)  mif--;
    if (mif > peak) peak = mif;
    if (!reset) begin
      chk("inflight_track", dut.inflight, mif);
      if (hash_valid) chk("credit_limit", mif < MI, 1'b1);
      if (rand_ready && prev_valid && !prev_ready) begin
        chk("stall_valid", hash_valid, 1'b1);
        chk("stall_nonce", hash_nonce, prev_nonce);
        chk("stall_header", hash_header, prev_hdr);
      end
    end
    if (done) ndone++;
    for (int i = 0; i < 15; i++) begin
      pv[i] = pv[i+1];
      pn[i] = pn[i+1];
    end
    pv[15] = 1'b0;
    res_valid  = pv[0];
    res_nonce  = pn[0];
    res_digest = {pn[0], 224'h0};
    hash_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    xfer = (hash_valid === 1'b1) && hash_ready && !reset;
    if (xfer) begin
      chk("issue_nonce", hash_nonce, exp_nonce);
      chk("issue_header", hash_header, {block_header[639:NW], exp_nonce});
      if (hash_nonce == '0) seen_zero = 1'b1;
      exp_nonce = exp_nonce + 1;
      n_issue++;
      pv[lat] = 1'b1;
      pn[lat] = hash_nonce;
    end
    prev_racc  = res_valid && (mif != 0) && !reset;
    prev_xfer  = xfer;
    prev_reset = reset;
    prev_valid = (hash_valid === 1'b1);
    prev_ready = hash_ready;
    prev_nonce = hash_nonce;
    prev_hdr   = hash_header;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic [639:0] hdr, input logic [NW-1:0] s, input logic [NW-1:0] e,
                           input logic [255:0] tgt, input int l, input bit rr);
    tick();
    block_header = hdr;
    nonce_start  = s;
    nonce_end    = e;
    target       = tgt;
    lat          = l;
    rand_ready   = rr;
    exp_nonce    = s;
    n_issue      = 0;
    ndone        = 0;
    peak         = 0;
    seen_zero    = 1'b0;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget && ndone == 0; k++) tick();
    chk({tag, "_done_seen"}, ndone != 0, 1'b1);
    repeat (4) tick();
    chk({tag, "_done_once"}, ndone, 1);
    chk({tag, "_inflight_zero"}, dut.inflight, 0);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    block_header = '0;
    nonce_start = '0;
    nonce_end = '0;
    target = '0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_found", found, 1'b0);
    chk("rst_found_nonce", found_nonce, 0);
    chk("rst_hash_valid", hash_valid, 1'b0);
    chk("rst_hash_header", hash_header, 0);
    chk("rst_hash_nonce", hash_nonce, 0);
    reset = 1'b0;
    tick();

    // Range 20..30, no hit
    start_job({8'hA5, 600'h0, 32'hDEAD_BEEF}, 32'd20, 32'd30, T16, 5, 1'b0);
    chk("t1_first_valid", hash_valid, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_first_nonce", hash_nonce, 32'd20);
    wait_done("t1", 200);
    chk("t1_issues", n_issue, 11);
    chk("t1_found", found, 1'b0);
`ifdef MINER_HASH_COUNT_EN
    chk("t1_hash_count", hash_count, 32'd11);
`endif

    // Range 10..40, first hit at nonce 10 stops issue after four credits
    start_job({640{1'b1}}, 32'd10, 32'd40, T16, 5, 1'b0);
    wait_done("t2", 200);
    chk("t2_found", found, 1'b1);
    chk("t2_found_nonce", found_nonce, 32'd10);
    chk("t2_issues", n_issue, 4);
`ifdef MINER_HASH_COUNT_EN
    chk("t2_hash_count", hash_count, 32'd4);
`endif

    // Credit limit with a 10-cycle pipeline
    start_job({320'h1234, 320'h5678}, 32'd100, 32'd107, T16, 10, 1'b0);
    wait_done("t3", 300);
    chk("t3_peak", peak, MI);
    chk("t3_issues", n_issue, 8);
    chk("t3_found", found, 1'b0);

    // Top of nonce space, no wrap
    start_job({640{1'b0}}, 32'hFFFF_FFFE, 32'hFFFF_FFFF, T16, 5, 1'b0);
    wait_done("t4a", 200);
    chk("t4a_issues", n_issue, 2);
    chk("t4a_no_wrap", seen_zero, 1'b0);

    // Empty range
    start_job({640{1'b0}}, 32'd5, 32'd4, T16, 5, 1'b0);
    chk("t4b_busy_c1", busy, 1'b1);
    chk("t4b_done_c1", done, 1'b0);
    tick();
    chk("t4b_done_c2", done, 1'b1);
    chk("t4b_busy_c2", busy, 1'b0);
    tick();
    chk("t4b_done_c3", done, 1'b0);
    chk("t4b_issues", n_issue, 0);

    // Random back-pressure over 0..63, no hits
    start_job({4'h9, 636'h0}, 32'd0, 32'd63, T0, 5, 1'b1);
    wait_done("t5", 3000);
    rand_ready = 1'b0;
    chk("t5_issues", n_issue, 64);
    chk("t5_found", found, 1'b0);
    chk("t5_next_nonce", exp_nonce, 32'd64);

    // Reset mid-ISSUE, then a fresh job while stale results drain into IDLE
    start_job({640{1'b1}}, 32'd1000, 32'd1063, T0, 5, 1'b0);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_valid", hash_valid, 1'b0);
    chk("t6_rst_inflight", dut.inflight, 0);
    reset = 1'b0;
    repeat (10) tick();
    start_job({8'h3C, 632'h0}, 32'd0, 32'd3, T16, 5, 1'b0);
    wait_done("t6", 200);
    chk("t6_found", found, 1'b1);
    chk("t6_found_nonce", found_nonce, 32'd0);
    chk("t6_issues", n_issue, 4);
`ifdef MINER_HASH_COUNT_EN
    chk("t6_hash_count", hash_count, 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
